// File: rtl/wb_traffic_gen_if.sv
// Wishbone classic/registered-burst bus between the traffic generator (master)
// and the memory slave under test.
interface wb_traffic_gen_if #(
    parameter int DW = 32,
    parameter int AW = 26
);
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_traffic_gen.sv
// Wishbone burst traffic generator: write, read, or write-then-readback-compare
// runs over an address-derived data pattern, with per-beat ack timeout.
module wb_traffic_gen #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int BL_MAX  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_traffic_gen_if.master    wb,
    input  logic                start,
    input  logic [1:0]          cfg_mode,
    input  logic [AW-1:0]       cfg_base_addr,
    input  logic [7:0]          cfg_num_bursts,
    input  logic [4:0]          cfg_burst_len,
    input  logic [31:0]         cfg_seed,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [15:0]         err_cnt,
    output logic [AW-1:0]       first_err_addr
);
    localparam int STEP = DW / 8;
    localparam int TW   = $clog2(TIMEOUT) + 1;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, FIN} state_t;

    state_t        state;
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic [31:0]   seed;
    logic [8:0]    nbursts;
    logic [4:0]    blen;
    logic [8:0]    burst_idx;
    logic [4:0]    beat_idx;
    logic [TW-1:0] wait_cnt;

    logic [4:0]    blen_clip;
    logic          last_beat;
    logic          last_burst;
    logic          restart;
    logic [AW-1:0] addr_nx;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [31:0] s);
        logic [31:0] w;
        w = 32'(a) ^ s;
        return {(DW/32){w}};
    endfunction

    always_comb begin
        blen_clip = cfg_burst_len;
        if (cfg_burst_len == 5'd0)
            blen_clip = 5'd1;
        else if (cfg_burst_len > 5'(BL_MAX))
            blen_clip = 5'(BL_MAX);
    end

    // Bursts are contiguous, so the next beat is always +STEP except when the
    // write phase hands over to the readback phase at the base address.
    always_comb begin
        last_beat  = (beat_idx == blen - 5'd1);
        last_burst = (burst_idx == nbursts - 9'd1);
        restart    = (state == WR) && last_beat && last_burst && (mode != 2'b00);
        addr_nx    = restart ? base : wb.wb_addr_o + AW'(STEP);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            wb.wb_cyc_o    <= 1'b0;
            wb.wb_stb_o    <= 1'b0;
            wb.wb_we_o     <= 1'b0;
            wb.wb_addr_o   <= '0;
            wb.wb_dat_o    <= '0;
            wb.wb_sel_o    <= '0;
            wb.wb_cti_o    <= 3'b000;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            mode           <= 2'b00;
            base           <= '0;
            seed           <= '0;
            nbursts        <= '0;
            blen           <= '0;
            burst_idx      <= '0;
            beat_idx       <= '0;
            wait_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode           <= cfg_mode;
                    base           <= cfg_base_addr;
                    seed           <= cfg_seed;
                    nbursts        <= (cfg_num_bursts == 8'd0) ? 9'd256 : {1'b0, cfg_num_bursts};
                    blen           <= blen_clip;
                    err_cnt        <= '0;
                    first_err_addr <= '0;
                    timeout        <= 1'b0;
                    busy           <= 1'b1;
                    burst_idx      <= '0;
                    beat_idx       <= '0;
                    wait_cnt       <= '0;
                    wb.wb_cyc_o    <= 1'b1;
                    wb.wb_stb_o    <= 1'b1;
                    wb.wb_we_o     <= (cfg_mode != 2'b01);
                    wb.wb_sel_o    <= '1;
                    wb.wb_addr_o   <= cfg_base_addr;
                    wb.wb_dat_o    <= pattern(cfg_base_addr, cfg_seed);
                    wb.wb_cti_o    <= (blen_clip == 5'd1) ? CTI_END : CTI_INCR;
                    state          <= (cfg_mode == 2'b01) ? RD : WR;
                end
                WR, RD: begin
                    if (wb.wb_ack_i) begin
                        wait_cnt <= '0;
                        // During reads wb_dat_o still carries the expected pattern.
                        if (state == RD && mode[1] && wb.wb_dat_i != wb.wb_dat_o) begin
                            if (err_cnt != 16'hFFFF)
                                err_cnt <= err_cnt + 16'd1;
                            if (err_cnt == 16'd0)
                                first_err_addr <= wb.wb_addr_o;
                        end
                        wb.wb_addr_o <= addr_nx;
                        wb.wb_dat_o  <= pattern(addr_nx, seed);
                        if (last_beat) begin
                            beat_idx    <= '0;
                            wb.wb_cyc_o <= 1'b0;
                            wb.wb_stb_o <= 1'b0;
                            wb.wb_we_o  <= 1'b0;
                            wb.wb_cti_o <= (blen == 5'd1) ? CTI_END : CTI_INCR;
                            if (!last_burst) begin
                                burst_idx <= burst_idx + 9'd1;
                                state     <= (state == WR) ? WGAP : RGAP;
                            end else if (restart) begin
                                burst_idx <= '0;
                                state     <= WGAP;
                            end else begin
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        end else begin
                            beat_idx    <= beat_idx + 5'd1;
                            wb.wb_cti_o <= (beat_idx + 5'd2 == blen) ? CTI_END : CTI_INCR;
                        end
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        timeout     <= 1'b1;
                        done        <= 1'b1;
                        state       <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                // burst_idx is only zero here when the write phase just finished.
                WGAP: begin
                    wb.wb_cyc_o <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                    wb.wb_we_o  <= (burst_idx != 9'd0);
                    wait_cnt    <= '0;
                    state       <= (burst_idx == 9'd0) ? RD : WR;
                end
                RGAP: begin
                    wb.wb_cyc_o <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                    wb.wb_we_o  <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= RD;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_traffic_gen.sv
// Bench for wb_traffic_gen: randomized runs against a memory slave with wait
// states, expected beats queued by a burst-level reference model.
module tb_wb_traffic_gen;
    localparam int DW = 32;
    localparam int AW = 26;
    localparam int BL_MAX = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [1:0] cfg_mode;
    logic [AW-1:0] cfg_base_addr;
    logic [7:0] cfg_num_bursts;
    logic [4:0] cfg_burst_len;
    logic [31:0] cfg_seed;
    logic busy, done, timeout;
    logic [15:0] err_cnt;
    logic [AW-1:0] first_err_addr;

    wb_traffic_gen_if #(.DW(DW), .AW(AW)) wb ();

    wb_traffic_gen #(.DW(DW), .AW(AW), .BL_MAX(BL_MAX), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb.master),
        .start(start), .cfg_mode(cfg_mode), .cfg_base_addr(cfg_base_addr),
        .cfg_num_bursts(cfg_num_bursts), .cfg_burst_len(cfg_burst_len), .cfg_seed(cfg_seed),
        .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic [31:0]   dat;
        bit            first_beat;
        bit            first_of_run;
    } beat_t;

    beat_t exp_q[$];
    logic [31:0] mem [logic [AW-1:0]];
    int checks = 0;
    int errors = 0;
    bit no_ack = 1'b0;
    int max_wait = 0;
    int wait_left = 0;
    int corrupt_idx = -1;
    int read_idx = 0;
    int low_cnt = 0;
    logic prev_cyc = 1'b0;
    int exp_err;
    logic [AW-1:0] exp_first;
    beat_t cur;
    logic [31:0] rd_word;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: beat list straight from the burst/beat address arithmetic.
    task automatic model_run(input logic [1:0] mode, input logic [AW-1:0] base, input int nb,
                             input int bl, input logic [31:0] seed, input int corrupt);
        int nbe, ble, nrd;
        bit first;
        logic [AW-1:0] a;
        beat_t b;
        nbe = (nb == 0) ? 256 : nb;
        ble = (bl < 1) ? 1 : ((bl > BL_MAX) ? BL_MAX : bl);
        first = 1'b1;
        exp_err = 0;
        exp_first = '0;
        nrd = 0;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0 && mode == 2'b01) continue;
            if (ph == 1 && mode == 2'b00) continue;
            for (int bu = 0; bu < nbe; bu++) begin
                for (int k = 0; k < ble; k++) begin
                    a = base + AW'((bu * ble + k) * 4);
                    b.we = (ph == 0);
                    b.addr = a;
                    b.cti = (k == ble - 1) ? 3'b111 : 3'b010;
                    b.dat = 32'(a) ^ seed;
                    b.first_beat = (k == 0);
                    b.first_of_run = first;
                    first = 1'b0;
                    exp_q.push_back(b);
                    if (ph == 1) begin
                        if (mode[1] && nrd == corrupt && exp_err == 0) begin
                            exp_err = 1;
                            exp_first = a;
                        end
                        nrd++;
                    end
                end
            end
        end
    endtask

    // Slave + monitor: decides ack at the falling edge and checks each beat it acks.
    always @(negedge clk) begin
        if (rst) begin
            wb.wb_ack_i = 1'b0;
            wb.wb_dat_i = '0;
            prev_cyc = 1'b0;
        end else begin
            if (wb.wb_cyc_o && !prev_cyc) begin
                if (exp_q.size() > 0 && !exp_q[0].first_of_run)
                    chk("gap_cycles", low_cnt, 1);
                low_cnt = 0;
            end
            if (!wb.wb_cyc_o) low_cnt++;
            prev_cyc = wb.wb_cyc_o;
            wb.wb_ack_i = 1'b0;
            if (wb.wb_cyc_o && wb.wb_stb_o && !no_ack) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    wb.wb_ack_i = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual addr=%0h required no beat", wb.wb_addr_o);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("beat", {wb.wb_we_o, wb.wb_addr_o, wb.wb_cti_o, wb.wb_sel_o,
                                     wb.wb_we_o ? wb.wb_dat_o : 32'h0},
                                    {cur.we, cur.addr, cur.cti, 4'hF, cur.we ? cur.dat : 32'h0});
                        if (wb.wb_we_o) begin
                            mem[wb.wb_addr_o] = wb.wb_dat_o;
                        end else begin
                            rd_word = mem.exists(wb.wb_addr_o) ? mem[wb.wb_addr_o] : $urandom;
                            if (read_idx == corrupt_idx) rd_word = rd_word ^ 32'h0000_0100;
                            wb.wb_dat_i = rd_word;
                            read_idx++;
                        end
                    end
                    wait_left = int'($urandom_range(0, 32'(max_wait)));
                end
            end
        end
    end

    task automatic pulse_start(input logic [1:0] mode, input logic [AW-1:0] base, input int nb,
                               input int bl, input logic [31:0] seed);
        cfg_mode = mode;
        cfg_base_addr = base;
        cfg_num_bursts = 8'(nb);
        cfg_burst_len = 5'(bl);
        cfg_seed = seed;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_mode = 2'($urandom);
        cfg_base_addr = AW'($urandom);
        cfg_num_bursts = 8'($urandom);
        cfg_burst_len = 5'($urandom);
        cfg_seed = $urandom;
    endtask

    task automatic run(input logic [1:0] mode, input logic [AW-1:0] base, input int nb, input int bl,
                       input logic [31:0] seed, input int corrupt, input int mw, input bit poke);
        bit got;
        exp_q.delete();
        mem.delete();
        model_run(mode, base, nb, bl, seed, corrupt);
        corrupt_idx = corrupt;
        read_idx = 0;
        max_wait = mw;
        wait_left = int'($urandom_range(0, 32'(mw)));
        pulse_start(mode, base, nb, bl, seed);
        chk("busy_after_start", busy, 1);
        if (poke) begin
            repeat (5) @(negedge clk);
            cfg_mode = 2'b01;
            cfg_base_addr = '0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual no done required done within 20000 cycles");
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        chk("err_cnt", err_cnt, exp_err);
        chk("first_err_addr", first_err_addr, exp_first);
        chk("timeout_clear", timeout, 0);
        chk("beats_left", exp_q.size(), 0);
        @(negedge clk);
        chk("busy_done_after", {busy, done}, 2'b00);
    endtask

    initial begin
        logic [AW-1:0] top;
        bit done_seen;
        int n;
        rst = 1'b1;
        start = 1'b0;
        cfg_mode = '0;
        cfg_base_addr = '0;
        cfg_num_bursts = '0;
        cfg_burst_len = '0;
        cfg_seed = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o,
                            wb.wb_sel_o, wb.wb_cti_o, busy, done, timeout, err_cnt, first_err_addr}, '0);
        rst = 1'b0;
        @(negedge clk);

        run(2'b00, AW'('h100), 2, 4, 32'h0, -1, 0, 1'b0);
        run(2'b10, AW'('h4000), 4, 8, 32'hA5A5A5A5, -1, 3, 1'b1);
        run(2'b10, AW'('h800), 2, 4, 32'h1234_5678, 5, 2, 1'b0);
        top = '1;
        top = top - AW'(7);
        run(2'b00, top, 1, 4, 32'h0, -1, 0, 1'b0);
        run(2'b01, AW'('h300), 2, 3, 32'hDEAD_BEEF, 1, 1, 1'b0);
        run(2'b11, AW'('h1000), 0, 0, 32'h0F0F_0F0F, 100, 0, 1'b0);
        for (int r = 0; r < 8; r++)
            run(2'($urandom_range(0, 3)), AW'($urandom) & ~AW'(3), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 20)),
                int'($urandom_range(0, 3)), 1'b0);

        // Silent slave: the bus must be released after TO cycles with strobe high.
        no_ack = 1'b1;
        exp_q.delete();
        pulse_start(2'b00, AW'('h40), 1, 4, 32'h0);
        n = 0;
        for (int i = 0; i < 100 && (wb.wb_cyc_o || n == 0); i++) begin
            if (wb.wb_cyc_o) n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_fin", {done, timeout, wb.wb_stb_o}, 3'b110);
        @(negedge clk);
        chk("timeout_after", {busy, done, timeout}, 3'b001);
        no_ack = 1'b0;

        // Reset while beat 2 of the first write burst is on the bus.
        exp_q.delete();
        mem.delete();
        model_run(2'b00, AW'('h200), 2, 4, 32'h5555_AAAA, -1);
        max_wait = 0;
        wait_left = 0;
        pulse_start(2'b00, AW'('h200), 2, 4, 32'h5555_AAAA);
        for (int i = 0; i < 100 && exp_q.size() > 6; i++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_async", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_addr_o, wb.wb_dat_o,
                               wb.wb_cti_o, busy, done}, '0);
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy || wb.wb_cyc_o) done_seen = 1'b1;
        end
        chk("reset_no_done_idle", done_seen, 0);
        run(2'b00, AW'('h100), 2, 4, 32'h0, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
